// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Each transaction runs IDLE -> EXEC -> RESP -> IDLE, with one transaction in flight.
// Optional feature: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win a
// simultaneous request. By default, arbitration is round-robin.
module alu_arbiter #(
  parameter int unsigned xlen = 64
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [xlen-1:0] req0_a,
  input  logic [xlen-1:0] req0_b,
  input  logic [2:0]      req0_ctrl,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [xlen-1:0] req1_a,
  input  logic [xlen-1:0] req1_b,
  input  logic [2:0]      req1_ctrl,

  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [xlen-1:0] rsp0_result,
  output logic            rsp0_zero,

  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [xlen-1:0] rsp1_result,
  output logic            rsp1_zero,

  output logic [xlen-1:0] alu_a,
  output logic [xlen-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [xlen-1:0] alu_result,
  input  logic            alu_zero,

  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [xlen-1:0] a_q, a_d;
  logic [xlen-1:0] b_q, b_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic            owner_q, owner_d;
  logic [xlen-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            grant;
  logic            rsp_ready_sel;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic            last_q, last_d;
`endif

  // Pick the requester that would win this cycle. This choice is only acted on in IDLE.
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = req1_valid && !req0_valid;
  end
`else
  // A lone request always wins. On a tie (or when nothing is requested), the requester
  // that was not served last is preferred.
  always_comb begin
    if (req0_valid ^ req1_valid) begin
      grant = req1_valid;
    end else begin
      grant = ~last_q;
    end
  end
`endif

  // Drive the handshake outputs, the shared-ALU outputs and the status output.
  always_comb begin
    req0_ready    = (state_q == StIdle) && !grant;
    req1_ready    = (state_q == StIdle) && grant;
    rsp0_valid    = (state_q == StResp) && !owner_q;
    rsp1_valid    = (state_q == StResp) && owner_q;
    rsp0_result   = result_q;
    rsp1_result   = result_q;
    rsp0_zero     = zero_q;
    rsp1_zero     = zero_q;
    // The ALU only ever sees registered operands, so requester inputs never reach it.
    alu_a         = a_q;
    alu_b         = b_q;
    alu_ctrl      = ctrl_q;
    busy          = (state_q != StIdle);
    rsp_ready_sel = owner_q ? rsp1_ready : rsp0_ready;
  end

  // Compute the next state, capture operands and results, and track the last-served requester.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    owner_d  = owner_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          ctrl_d  = grant ? req1_ctrl : req0_ctrl;
          owner_d = grant;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = StResp;
      end
      StResp: begin
        if (rsp_ready_sel) begin
          state_d = StIdle;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d  = owner_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers. Reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level model plus directed scenarios
// and randomized traffic. The bench also supplies the combinational ALU.
module tb_alu_arbiter;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req0_valid, req1_valid, req0_ready, req1_ready;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]      req0_ctrl, req1_ctrl;
  logic            rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [XLEN-1:0] rsp0_result, rsp1_result;
  logic            rsp0_zero, rsp1_zero;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [2:0]      alu_ctrl;
  logic            alu_zero;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.xlen(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .rsp0_zero  (rsp0_zero),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .rsp1_zero  (rsp1_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  // Reference ALU: AND, OR, ADD, SUB, SLT; undefined codes produce 0.
  function automatic logic [XLEN-1:0] alu_fn(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == '0);
  end

  // Winner rule: a lone request wins. On a tie or no request, round-robin prefers the
  // requester not served last; fixed priority prefers requester 0.
  function automatic bit pick(input bit v0, input bit v1, input bit last);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return ~last;
`endif
  endfunction

  // Transaction-level model: the age of the in-flight transaction, counted in cycles since acceptance.
  bit              m_busy;
  int              m_age;
  bit              m_owner;
  logic [XLEN-1:0] m_a, m_b, m_res;
  logic [2:0]      m_c;
  bit              m_zero;
  bit              m_last;
  bit              m_win;
  int              grant_log[$];

  always_comb m_win = pick(req0_valid, req1_valid, m_last);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_age   <= 0;
      m_owner <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      m_c     <= '0;
      m_res   <= '0;
      m_zero  <= 1'b0;
      m_last  <= 1'b1;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        m_busy  <= 1'b1;
        m_age   <= 1;
        m_owner <= m_win;
        m_a     <= m_win ? req1_a : req0_a;
        m_b     <= m_win ? req1_b : req0_b;
        m_c     <= m_win ? req1_ctrl : req0_ctrl;
        grant_log.push_back(int'(m_win));
      end
    end else if (m_age == 1) begin
      m_age  <= 2;
      m_res  <= alu_fn(m_a, m_b, m_c);
      m_zero <= (alu_fn(m_a, m_b, m_c) == '0);
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_busy <= 1'b0;
      m_last <= m_owner;
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m.busy", busy, m_busy);
      chk("m.req0_ready", req0_ready, !m_busy && !m_win);
      chk("m.req1_ready", req1_ready, !m_busy && m_win);
      chk("m.rsp0_valid", rsp0_valid, m_busy && m_age >= 2 && !m_owner);
      chk("m.rsp1_valid", rsp1_valid, m_busy && m_age >= 2 && m_owner);
      chk("m.rsp0_result", rsp0_result, m_res);
      chk("m.rsp1_result", rsp1_result, m_res);
      chk("m.rsp0_zero", rsp0_zero, m_zero);
      chk("m.rsp1_zero", rsp1_zero, m_zero);
      chk("m.alu_a", alu_a, m_a);
      chk("m.alu_b", alu_b, m_b);
      chk("m.alu_ctrl", alu_ctrl, m_c);
    end
  end

  logic acc0, acc1;
  always @(posedge clk) begin
    acc0 <= req0_valid && req0_ready;
    acc1 <= req1_valid && req1_ready;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_owner;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    #1 rst = 1'b1;
    #2 chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.req0_ready", req0_ready, 1);
    chk("rst.req1_ready", req1_ready, 0);
    chk("rst.rsp0_valid", rsp0_valid, 0);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_ctrl", alu_ctrl, 0);

    // Req0 alone: AND of 1010/0101.
    cyc();
    req0_valid = 1; req0_a = 64'hA; req0_b = 64'h5; req0_ctrl = 3'b000; rsp0_ready = 1;
    @(negedge clk);
    chk("t1.req0_ready", req0_ready, 1);
    cyc();
    req0_valid = 0;
    @(negedge clk);
    chk("t1.exec_busy", busy, 1);
    chk("t1.exec_rsp0_valid", rsp0_valid, 0);
    cyc();
    @(negedge clk);
    chk("t1.rsp0_valid", rsp0_valid, 1);
    chk("t1.result", rsp0_result, 0);
    chk("t1.zero", rsp0_zero, 1);
    chk("t1.rsp1_valid", rsp1_valid, 0);
    cyc();
    @(negedge clk);
    chk("t1.idle_busy", busy, 0);

    // Req1 alone: OR under 5 cycles of backpressure.
    cyc();
    req1_valid = 1; req1_a = 64'hA; req1_b = 64'h5; req1_ctrl = 3'b001; rsp1_ready = 0;
    @(negedge clk);
    chk("t2.req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2.rsp1_valid", rsp1_valid, 1);
      chk("t2.result", rsp1_result, 64'hF);
      chk("t2.zero", rsp1_zero, 0);
      chk("t2.busy", busy, 1);
      cyc();
    end
    rsp1_ready = 1;
    @(negedge clk);
    chk("t2.rsp1_valid_last", rsp1_valid, 1);
    cyc();
    @(negedge clk);
    chk("t2.idle_busy", busy, 0);

    // Reset, then both requesters held valid for four transactions.
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    grant_log.delete();
    req0_valid = 1; req0_a = 64'd5; req0_b = 64'd3; req0_ctrl = 3'b010;
    req1_valid = 1; req1_a = 64'd5; req1_b = 64'd3; req1_ctrl = 3'b110;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_owner = 0;
`else
      exp_owner = k % 2;
`endif
      @(negedge clk);
      chk("t3.req0_ready", req0_ready, exp_owner == 0);
      chk("t3.req1_ready", req1_ready, exp_owner == 1);
      cyc();
      @(negedge clk);
      chk("t3.busy", busy, 1);
      cyc();
      @(negedge clk);
      chk("t3.rsp0_valid", rsp0_valid, exp_owner == 0);
      chk("t3.rsp1_valid", rsp1_valid, exp_owner == 1);
      chk("t3.result", rsp0_result, (exp_owner == 0) ? 64'd8 : 64'd2);
      chk("t3.zero", rsp0_zero, 0);
      cyc();
    end
    req0_valid = 0; req1_valid = 0;
    chk("t3.grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("t3.grant_seq", grant_log[k], 0);
`else
      chk("t3.grant_seq", grant_log[k], k % 2);
`endif
    end

    // Reset pulsed while a SLT transaction is in EXEC.
    cyc();
    req0_valid = 1; req0_a = 64'd3; req0_b = 64'd7; req0_ctrl = 3'b111;
    @(negedge clk);
    chk("t4.req0_ready", req0_ready, 1);
    cyc();
    req0_valid = 0;
    rst = 1;
    #1;
    chk("t4.rsp0_valid", rsp0_valid, 0);
    chk("t4.busy", busy, 0);
    chk("t4.alu_a", alu_a, 0);
    chk("t4.alu_b", alu_b, 0);
    chk("t4.alu_ctrl", alu_ctrl, 0);
    chk("t4.result", rsp0_result, 0);
    @(negedge clk);
    rst = 0;
    cyc();
    @(negedge clk);
    chk("t4.post_busy", busy, 0);
    chk("t4.post_rsp0_valid", rsp0_valid, 0);

    // Req1 SUB 7-7, with req0 arriving during EXEC.
    cyc();
    req1_valid = 1; req1_a = 64'd7; req1_b = 64'd7; req1_ctrl = 3'b110;
    @(negedge clk);
    chk("t5.req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 0;
    req0_valid = 1; req0_a = 64'd1; req0_b = 64'd1; req0_ctrl = 3'b011;
    @(negedge clk);
    chk("t5.exec_req0_ready", req0_ready, 0);
    cyc();
    @(negedge clk);
    chk("t5.rsp1_valid", rsp1_valid, 1);
    chk("t5.result", rsp1_result, 0);
    chk("t5.zero", rsp1_zero, 1);
    chk("t5.resp_req0_ready", req0_ready, 0);
    cyc();
    @(negedge clk);
    chk("t5.idle_req0_ready", req0_ready, 1);
    cyc();
    req0_valid = 0;
    repeat (3) cyc();

    // Randomized traffic: a requester holds its request until it is accepted.
    grant_log.delete();
    for (int n = 0; n < 1500; n++) begin
      cyc();
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a     = rnd();
        req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : rnd();
        req0_ctrl  = 3'($urandom_range(0, 7));
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a     = rnd();
        req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : rnd();
        req1_ctrl  = 3'($urandom_range(0, 7));
      end
      rsp0_ready = ($urandom_range(0, 1) != 0);
      rsp1_ready = ($urandom_range(0, 1) != 0);
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (5) cyc();
    chk("rand.progress", (grant_log.size() > 100) ? 1 : 0, 1);
    chk("rand.drained_busy", busy, 0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: xlen, 64, operand/result width in bits.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports per requester i in {0,1}: req<i>_valid input 1 request present; req<i>_ready output 1 request accepted; req<i>_a input xlen operand a; req<i>_b input xlen operand b; req<i>_ctrl input 3 ALU op code.
REQ-004 SHALL have ports per requester i: rsp<i>_valid output 1 response present; rsp<i>_ready input 1 response consumed; rsp<i>_result output xlen ALU result; rsp<i>_zero output 1 ALU zero flag.
REQ-005 SHALL have shared-ALU ports: alu_a output xlen; alu_b output xlen; alu_ctrl output 3; alu_result input xlen; alu_zero input 1 (ALU is combinational).
REQ-006 SHALL have port busy output 1, high in any state other than IDLE.

Function
REQ-007 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one transaction in flight at a time.
REQ-008 IDLE: req<i>_ready SHALL equal (state==IDLE) && grant==i, combinationally; at most one ready high per cycle.
REQ-009 IDLE with any req_valid: SHALL register winner's a, b, ctrl and owner id, move to EXEC next cycle.
REQ-010 Arbitration default: round-robin; on simultaneous valids, winner is the requester not served last; single valid always wins.
REQ-011 EXEC: alu_a/alu_b/alu_ctrl SHALL drive registered operands; alu_result/alu_zero SHALL be registered at clock edge ending EXEC; move to RESP.
REQ-012 Outside EXEC alu_a, alu_b, alu_ctrl SHALL hold the registered operands (no glitch to requester inputs).
REQ-013 RESP: rsp<owner>_valid SHALL be high, other rsp_valid low; rsp_result/rsp_zero held stable until handshake.
REQ-014 RESP with rsp<owner>_ready high: SHALL return to IDLE next cycle and update last-served to owner; otherwise hold RESP indefinitely (backpressure).
REQ-015 Latency: request accepted at edge N -> rsp_valid high in cycle N+2; peak throughput one transaction per 3 cycles.
REQ-016 rsp<i>_result/rsp<i>_zero SHALL be driven from the shared result register for both requesters; only rsp_valid qualifies.
REQ-017 Requests arriving while not IDLE SHALL be held off (ready low); requester must keep valid and operands stable.
REQ-018 alu_ctrl codes SHALL pass through unchanged, including undefined codes (011, 100, 101).
REQ-019 req_valid dropping in IDLE without handshake SHALL not start a transaction.

Reset
REQ-020 rst high SHALL asynchronously force: state IDLE, operand/result/owner registers 0, last-served = 1 (requester 0 wins first tie).
REQ-021 Reset value of outputs: req_ready per REQ-008 from IDLE, rsp_valid 0, rsp_result 0, rsp_zero 0, alu_a 0, alu_b 0, alu_ctrl 000, busy 0.
REQ-022 Reset mid-EXEC or mid-RESP SHALL abort the transaction with no response issued; after release behaviour equals post-reset.

Configuration
REQ-023 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins simultaneous requests; last-served register not implemented.
REQ-024 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-010.

Verification
REQ-025 Req0 a=1010 b=0101 ctrl=000 alone -> req0_ready at accept, rsp0_valid 2 cycles later, result 0, zero 1, rsp1_valid 0.
REQ-026 Req1 a=1010 b=0101 ctrl=001 alone, rsp1_ready held low 5 cycles -> rsp1_valid and result 1111, zero 0 stable all 5 cycles; busy high throughout.
REQ-027 Both valid after reset, a=5 b=3 ctrl=010 (req0), ctrl=110 (req1), held -> req0 served first (8, zero 0), then req1 (2, zero 0); round-robin build: third tie goes to req1 again only if req0 was last.
REQ-028 Both valid continuously for 4 transactions -> grants alternate 0,1,0,1 (round-robin); with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-029 Req0 ctrl=111 a=3 b=7 accepted, rst pulsed in EXEC -> no rsp0_valid, all outputs at reset values, busy 0 next cycle.
REQ-030 Req1 ctrl=110 a=7 b=7 -> result 0, zero 1; req0 asserted during EXEC sees ready low until IDLE.
